// File: rtl/usb_reset_sequencer.sv
// USB subsystem reset sequencer: arbitrates sw/hw reset requests and drives a timed pulse + settle interval.
// Optional completion interrupt and IRQ CSR are enabled with `define USB_RST_SEQ_IRQ_EN.
module usb_reset_sequencer #(
  parameter int NUM_REQ   = 3,
  parameter int CNT_W     = 16,
  parameter int PULSE_DEF = 16,
  parameter int HOLD_DEF  = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic               usb_reset_out,
  output logic               busy,
  output logic               irq
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ASSERT = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [2:0] SRC_SW  = 3'd6;
  localparam logic [2:0] SRC_POR = 3'd7;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pulse_r, hold_r;
  logic [CNT_W-1:0] lat_pulse, lat_hold;
  logic [2:0]       src;
  logic [2:0]       rr_ptr;
  logic             sw_pend;
  logic             irq_en;
  logic             done_flag;

  logic wr;
  assign wr = chipselect && !write_n;

  logic wr_ctrl, wr_pulse, wr_hold, wr_irq;
  assign wr_ctrl  = wr && (address == 3'd0);
  assign wr_pulse = wr && (address == 3'd1);
  assign wr_hold  = wr && (address == 3'd2);
  assign wr_irq   = wr && (address == 3'd4);

  // Round-robin: rotate req so rr_ptr sits at bit 0, take the lowest set bit.
  logic [2*NUM_REQ-1:0] req2, rot;
  logic                 grant_hw;
  logic [2:0]           grant_off, grant_idx, next_ptr;
  logic [3:0]           sum;

  assign req2 = {req, req};

  always_comb begin
    rot       = req2 >> rr_ptr;
    grant_hw  = 1'b0;
    grant_off = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        grant_hw  = 1'b1;
        grant_off = 3'(k);
      end
    end
    sum       = {1'b0, rr_ptr} + {1'b0, grant_off};
    grant_idx = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
    next_ptr  = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
  end

  // A zero PULSE still produces a one-cycle pulse.
  logic [CNT_W-1:0] p_last, h_last;
  assign p_last = (lat_pulse == '0) ? '0 : lat_pulse - 1'b1;
  assign h_last = lat_hold - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_ASSERT;
      cnt       <= '0;
      pulse_r   <= CNT_W'(PULSE_DEF);
      hold_r    <= CNT_W'(HOLD_DEF);
      lat_pulse <= CNT_W'(PULSE_DEF);
      lat_hold  <= CNT_W'(HOLD_DEF);
      src       <= SRC_POR;
      rr_ptr    <= 3'd0;
      sw_pend   <= 1'b0;
    end else begin
      if (wr_pulse) pulse_r <= writedata[CNT_W-1:0];
      if (wr_hold)  hold_r  <= writedata[CNT_W-1:0];

      if (state == S_DONE && src == SRC_SW) sw_pend <= 1'b0;
      else if (wr_ctrl && writedata[0])     sw_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (sw_pend || grant_hw) begin
            state     <= S_ASSERT;
            cnt       <= '0;
            lat_pulse <= pulse_r;
            lat_hold  <= hold_r;
            if (sw_pend) src <= SRC_SW;
            else begin
              src    <= grant_idx;
              rr_ptr <= next_ptr;
            end
          end
        end
        S_ASSERT: begin
          if (cnt == p_last) begin
            cnt   <= '0;
            state <= (lat_hold != '0) ? S_HOLD : S_DONE;
          end else cnt <= cnt + 1'b1;
        end
        S_HOLD: begin
          if (cnt == h_last) begin
            cnt   <= '0;
            state <= S_DONE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef USB_RST_SEQ_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en    <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= writedata[1];
      // A completion in the same cycle as a clear keeps the flag set.
      if (state == S_DONE)            done_flag <= 1'b1;
      else if (wr_irq && writedata[0]) done_flag <= 1'b0;
    end
  end
  assign irq = done_flag & irq_en;
`else
  assign irq_en    = 1'b0;
  assign done_flag = 1'b0;
  assign irq       = 1'b0;
`endif

  assign usb_reset_out = (state == S_ASSERT);
  assign busy          = (state != S_IDLE);

  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_REQ; i++)
      ack[i] = (state == S_DONE) && (src == 3'(i));
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      3'd0: readdata = {30'd0, irq_en, 1'b0};
      3'd1: readdata = 32'(pulse_r);
      3'd2: readdata = 32'(hold_r);
      3'd3: readdata = {25'd0, src, 2'b00, sw_pend, busy};
      3'd4: readdata = {31'd0, done_flag};
      default: readdata = 32'd0;
    endcase
  end

  logic unused_wdata;
  assign unused_wdata = ^{writedata, wr_irq};

endmodule

// File: tb/tb_usb_reset_sequencer.sv
// Scoreboard bench for usb_reset_sequencer: stimulus pushes expected sequence shapes, a monitor measures and compares.
module tb_usb_reset_sequencer;
  localparam int NR = 3;
`ifdef USB_RST_SEQ_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    address = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [31:0]   readdata;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] ack;
  logic          usb_reset_out, busy, irq;

  usb_reset_sequencer #(.NUM_REQ(NR), .CNT_W(16), .PULSE_DEF(16), .HOLD_DEF(64)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .req(req), .ack(ack), .usb_reset_out(usb_reset_out), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            p;
    int            h;
    logic [NR-1:0] ackv;
    int            pos;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int p, input int h, input logic [NR-1:0] a);
    exp_t e;
    e.p = p; e.h = h; e.ackv = a;
    e.pos = (a != '0) ? p + h + 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    csr_rd(a, d);
    check(name, d, exp);
  endtask

  // Requesters drop their line on ack; the wait is bounded.
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    forever begin
      tick();
      req = req & ~ack;
      if (exp_q.size() == 0 && !busy) break;
      n++;
      if (n > budget) begin
        n_chk++; n_fail++;
        $display("FAIL timeout: %0d sequences still outstanding after %0d cycles", exp_q.size(), budget);
        exp_q.delete();
        req = '0;
        break;
      end
    end
  endtask

  // Monitor: measures pulse/settle lengths and ack of each sequence when busy falls.
  initial begin
    int            hi, lo, pos;
    logic [NR-1:0] acc;
    logic          pb;
    exp_t          e;
    hi = 0; lo = 0; pos = 0; acc = '0; pb = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        hi = 0; lo = 0; pb = 1'b1;
      end else begin
        if (busy) begin
          if (usb_reset_out) hi++;
          else lo++;
          if (ack != '0) begin
            acc = acc | ack;
            pos = hi + lo;
          end
        end else if (pb) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_seq: pulse %0d settle %0d ack %b with nothing expected", hi, lo - 1, acc);
          end else begin
            e = exp_q.pop_front();
            check("pulse_len", 32'(hi), 32'(e.p));
            check("hold_len", 32'(lo - 1), 32'(e.h));
            check("ack_vec", 32'(acc), 32'(e.ackv));
            check("ack_pos", 32'(pos), 32'(e.pos));
          end
          hi = 0; lo = 0; pos = 0; acc = '0;
        end
        pb = busy;
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_out", 32'(usb_reset_out), 32'd1);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rd_check("rst_pulse", 3'd1, 32'd16);
    rd_check("rst_hold", 3'd2, 32'd64);
    rd_check("rst_status", 3'd3, 32'h71);
    tick();
    rd_check("rst_ctrl", 3'd0, 32'd0);
    rd_check("rst_irqreg", 3'd4, 32'd0);

    // Power-on sequence
    push(16, 64, '0);
    tick();
    reset = 1'b0;
    wait_idle(200);
    rd_check("por_status", 3'd3, 32'h70);

    // Short pulse, no settle, hw requester 1
    csr_wr(3'd1, 32'd4);
    csr_wr(3'd2, 32'd0);
    push(4, 0, 3'b010);
    req[1] = 1'b1;
    wait_idle(100);
    rd_check("req1_status", 3'd3, 32'h10);

    // PULSE=0 yields a one-cycle pulse
    csr_wr(3'd1, 32'd0);
    push(1, 0, 3'b001);
    req[0] = 1'b1;
    wait_idle(100);

    // PULSE rewritten mid-ASSERT affects only the next sequence
    csr_wr(3'd1, 32'd6);
    push(6, 0, 3'b010);
    req[1] = 1'b1;
    tick(); tick();
    csr_wr(3'd1, 32'd9);
    wait_idle(100);
    rd_check("pulse_rb", 3'd1, 32'd9);
    push(9, 0, 3'b100);
    req[2] = 1'b1;
    wait_idle(100);

    // sw request beats hw, then round-robin 0 then 2, back to back
    csr_wr(3'd2, 32'd2);
    csr_wr(3'd0, 32'd1);
    rd_check("swpend_status", 3'd3, 32'h22);
    push(9, 2, '0);
    push(9, 2, 3'b001);
    push(9, 2, 3'b100);
    req = 3'b101;
    wait_idle(300);
    rd_check("arb_status", 3'd3, 32'h20);

    // Completion interrupt
    csr_wr(3'd4, 32'd1);
    csr_wr(3'd0, 32'd2);
    check("irq_idle", 32'(irq), 32'd0);
    csr_wr(3'd0, 32'd3);
    push(9, 2, '0);
    wait_idle(100);
    check("irq_done", 32'(irq), 32'(IRQ));
    rd_check("ctrl_rb", 3'd0, IRQ ? 32'd2 : 32'd0);
    rd_check("sw_status", 3'd3, 32'h60);
    rd_check("irq_flag", 3'd4, 32'(IRQ));
    tick();
    csr_wr(3'd4, 32'd1);
    check("irq_cleared", 32'(irq), 32'd0);
    rd_check("irq_flag_clr", 3'd4, 32'd0);

    // Reset mid-HOLD aborts without ack and restarts power-on
    csr_wr(3'd1, 32'd2);
    csr_wr(3'd2, 32'd20);
    req[1] = 1'b1;
    repeat (6) tick();
    check("abort_in_hold", {30'd0, busy, usb_reset_out}, 32'd2);
    reset = 1'b1;
    req = '0;
    push(16, 64, '0);
    tick();
    check("abort_rst_out", 32'(usb_reset_out), 32'd1);
    check("abort_rst_ack", 32'(ack), 32'd0);
    rd_check("abort_pulse", 3'd1, 32'd16);
    tick();
    reset = 1'b0;
    check("rel_out", 32'(usb_reset_out), 32'd1);
    tick();
    check("rel_out2", 32'(usb_reset_out), 32'd1);
    wait_idle(200);
    rd_check("abort_status", 3'd3, 32'h70);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
